// File: rtl/divide_arbiter_pkg.sv
// Shared types and constants for the divider arbiter slice.
// State encoding, error quotient pattern, exponent width and a
// constant-evaluable clog2 used to size IDs and the watchdog.
package divide_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam int EXP_W = 6;

  // Wide enough for any practical DSIZE; sliced to 2*DSIZE at use.
  localparam logic [127:0] ERR_Q = '1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/divide_arbiter_if.sv
// Requester-side bus of the divider arbiter: request handshake with
// packed operands plus the shared one-cycle response pulse.
// slave = arbiter side, master = client side.
interface divide_arbiter_if
  import divide_arb_pkg::*;
#(
  parameter int DSIZE = 24,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) ();
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_n;
  logic [NREQ*DSIZE-1:0] req_d;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic [IDW-1:0]        resp_id;
  logic [2*DSIZE-1:0]    resp_q;
  logic [EXP_W-1:0]      resp_exp;
  logic                  resp_err;

  modport slave (
    input  req_valid, req_n, req_d,
    output req_ready, resp_valid, resp_id, resp_q, resp_exp, resp_err
  );

  modport master (
    output req_valid, req_n, req_d,
    input  req_ready, resp_valid, resp_id, resp_q, resp_exp, resp_err
  );
endinterface

// File: rtl/divide_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping around; returns one-hot grant, index and any-flag.
module divide_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  logic           found;
  logic [IDW-1:0] cidx;

  // Scan from the pointer upward; the first hit wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cidx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cidx = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[cidx]) begin
        found       = 1'b1;
        idx_o       = cidx;
        gnt_o[cidx] = 1'b1;
      end
    end
  end

  assign any_o = found;
endmodule

// File: rtl/divide_arbiter.sv
// Round-robin sharing of one divide_Newton instance among NREQ clients.
// IDLE picks a winner and pulses its grant, ISSUE fires the divider
// enable, WAIT runs a watchdog until VALID, RESP pulses the answer.
// Optional: DIVARB_ZERO_BYPASS_EN answers zero-divisor requests with an
// error response without touching the divider.
module divide_arbiter
  import divide_arb_pkg::*;
#(
  parameter int DSIZE   = 24,
  parameter int NREQ    = 4,
  parameter int IDW     = clog2(NREQ),
  parameter int TIMEOUT = 63
) (
  input  logic               clock,
  input  logic               rst,
  divide_arbiter_if.slave    bus,
  output logic               busy,
  output logic [DSIZE-1:0]   div_n,
  output logic [DSIZE-1:0]   div_d,
  output logic               div_enable,
  input  logic [2*DSIZE-1:0] div_q,
  input  logic [EXP_W-1:0]   div_exp,
  input  logic               div_valid,
  input  logic               div_rdy
);
  localparam int WDW = clog2(TIMEOUT + 1);

  arb_state_e         state_q;
  logic [IDW-1:0]     ptr_q, ptr_d;
  logic [WDW-1:0]     wd_q;
  logic [IDW-1:0]     cur_id_q;
  logic [NREQ-1:0]    req_ready_q;
  logic               resp_valid_q;
  logic [IDW-1:0]     resp_id_q;
  logic [2*DSIZE-1:0] resp_q_q;
  logic [EXP_W-1:0]   resp_exp_q;
  logic               resp_err_q;
  logic               busy_q;
  logic [DSIZE-1:0]   div_n_q, div_d_q;
  logic               div_enable_q;
`ifdef DIVARB_ZERO_BYPASS_EN
  logic               byp_q;
`endif

  logic [DSIZE-1:0]   n_arr [NREQ];
  logic [DSIZE-1:0]   d_arr [NREQ];
  logic [NREQ-1:0]    pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign n_arr[i] = bus.req_n[i*DSIZE +: DSIZE];
    assign d_arr[i] = bus.req_d[i*DSIZE +: DSIZE];
  end

  divide_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // Pointer moves one past the winner, wrapping at NREQ.
  always_comb begin
    ptr_d = (pick_idx == IDW'(NREQ - 1)) ? '0 : pick_idx + IDW'(1);
  end

  // Arbitration FSM; every output is a register loaded here.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      wd_q         <= '0;
      cur_id_q     <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_q_q     <= '0;
      resp_exp_q   <= '0;
      resp_err_q   <= 1'b0;
      busy_q       <= 1'b0;
      div_n_q      <= '0;
      div_d_q      <= '0;
      div_enable_q <= 1'b0;
`ifdef DIVARB_ZERO_BYPASS_EN
      byp_q        <= 1'b0;
`endif
    end else begin
      req_ready_q  <= '0;
      div_enable_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (div_rdy && pick_any) begin
            req_ready_q <= pick_gnt;
            div_n_q     <= n_arr[pick_idx];
            div_d_q     <= d_arr[pick_idx];
            cur_id_q    <= pick_idx;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b1;
`ifdef DIVARB_ZERO_BYPASS_EN
            if (d_arr[pick_idx] == '0) begin
              state_q <= RESP;
              byp_q   <= 1'b1;
            end else begin
              state_q <= ISSUE;
            end
`else
            state_q     <= ISSUE;
`endif
          end
        end
        ISSUE: begin
          div_enable_q <= 1'b1;
          wd_q         <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          if (div_valid) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= cur_id_q;
            resp_q_q     <= div_q;
            resp_exp_q   <= div_exp;
            resp_err_q   <= 1'b0;
            state_q      <= RESP;
          end else if (wd_q == WDW'(TIMEOUT - 1)) begin
            resp_valid_q <= 1'b1;
            resp_id_q    <= cur_id_q;
            resp_q_q     <= ERR_Q[2*DSIZE-1:0];
            resp_exp_q   <= '0;
            resp_err_q   <= 1'b1;
            state_q      <= RESP;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        RESP: begin
`ifdef DIVARB_ZERO_BYPASS_EN
          if (byp_q) begin
            // Grant cycle is done; now present the error response.
            byp_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_id_q    <= cur_id_q;
            resp_q_q     <= ERR_Q[2*DSIZE-1:0];
            resp_exp_q   <= '0;
            resp_err_q   <= 1'b1;
          end else begin
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end
`else
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          state_q      <= IDLE;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_q     = resp_q_q;
  assign bus.resp_exp   = resp_exp_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = busy_q;
  assign div_n          = div_n_q;
  assign div_d          = div_d_q;
  assign div_enable     = div_enable_q;
endmodule

// File: tb/tb_divide_arbiter.sv
// Directed bench for divide_arbiter with a 12-cycle divider model.
// Honours DIVARB_ZERO_BYPASS_EN to pick the zero-divisor expectation.
module tb_divide_arbiter;
  localparam int DSIZE   = 24;
  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 63;

  logic clock = 1'b0;
  logic rst;
  always #5 clock = ~clock;

  divide_arbiter_if #(.DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW)) bus ();

  logic               busy, div_enable, div_valid, div_rdy;
  logic [DSIZE-1:0]   div_n, div_d;
  logic [2*DSIZE-1:0] div_q;
  logic [5:0]         div_exp;

  divide_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clock      (clock),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .div_n      (div_n),
    .div_d      (div_d),
    .div_enable (div_enable),
    .div_q      (div_q),
    .div_exp    (div_exp),
    .div_valid  (div_valid),
    .div_rdy    (div_rdy)
  );

  // Divider model: RDY low from enable until VALID, VALID 12 cycles after enable.
  logic               m_rdy, m_busy, m_valid, m_stall, m_hold;
  int                 m_cnt;
  logic [2*DSIZE-1:0] m_opq, m_q;
  logic [5:0]         m_exp;

  always @(posedge clock or posedge rst) begin
    if (rst) begin
      m_rdy <= 1'b1; m_busy <= 1'b0; m_valid <= 1'b0; m_cnt <= 0;
      m_opq <= '0; m_q <= '0; m_exp <= '0;
    end else begin
      m_valid <= 1'b0;
      if (div_enable) begin
        m_rdy  <= 1'b0;
        m_busy <= !m_stall;
        m_cnt  <= 11;
        m_opq  <= {div_n, div_d};
      end else if (m_busy) begin
        if (m_cnt == 1) begin
          m_valid <= 1'b1; m_q <= m_opq; m_exp <= 6'h2A;
          m_busy <= 1'b0; m_rdy <= 1'b1;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (!m_rdy && !m_stall) begin
        m_rdy <= 1'b1;
      end
    end
  end

  assign div_rdy   = m_rdy & ~m_hold;
  assign div_valid = m_valid;
  assign div_q     = m_q;
  assign div_exp   = m_exp;

  // Event log used by the fairness scenario.
  logic [3:0]         gq[$];
  int                 rid_q[$];
  logic [2*DSIZE-1:0] rq_q[$];
  int                 overlap;

  always @(negedge clock) begin
    if (bus.req_ready != 4'b0000) gq.push_back(bus.req_ready);
    if (bus.resp_valid) begin
      rid_q.push_back(int'(bus.resp_id));
      rq_q.push_back(bus.resp_q);
    end
    if (div_enable && (m_busy || !m_rdy)) overlap++;
  end

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_op(input int i, input logic [DSIZE-1:0] n, input logic [DSIZE-1:0] d);
    bus.req_n[i*DSIZE +: DSIZE] = n;
    bus.req_d[i*DSIZE +: DSIZE] = d;
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clock);
      if (bus.req_ready != 4'b0000) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 120; t++) begin
      @(negedge clock);
      if (bus.resp_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; m_stall = 1'b0; m_hold = 1'b0; bus.req_valid = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.req_valid = '0;
    repeat (2) tick();
    checks++; if (busy !== 1'b0 || div_enable !== 1'b0) begin errors++; $display("FAIL reset_ctl: busy=%b en=%b want 0 0", busy, div_enable); end
    checks++; if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_hs: ready=%b rv=%b want 0000 0", bus.req_ready, bus.resp_valid); end
    checks++; if (bus.resp_q !== 48'd0 || div_n !== 24'd0 || div_d !== 24'd0) begin errors++; $display("FAIL reset_data: q=%h n=%h d=%h want 0", bus.resp_q, div_n, div_d); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    set_op(1, 24'd6, 24'd3);
    bus.req_valid = 4'b0010;
    wait_grant(ok);
    checks++; if (!ok || bus.req_ready !== 4'b0010) begin errors++; $display("FAIL single_grant: got %b want 0010", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
    checks++; if (div_enable !== 1'b1 || bus.req_ready !== 4'b0000) begin errors++; $display("FAIL single_enable: en=%b ready=%b want 1 0000", div_enable, bus.req_ready); end
    checks++; if (div_n !== 24'd6 || div_d !== 24'd3) begin errors++; $display("FAIL single_ops: n=%0d d=%0d want 6 3", div_n, div_d); end
    tick();
    checks++; if (div_enable !== 1'b0) begin errors++; $display("FAIL single_enable_once: en=%b want 0", div_enable); end
    repeat (11) tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL single_early: rv=%b want 0 at grant+13", bus.resp_valid); end
    tick();
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'd1) begin errors++; $display("FAIL single_resp: rv=%b id=%0d want 1 1", bus.resp_valid, bus.resp_id); end
    checks++; if (bus.resp_q !== {24'd6, 24'd3} || bus.resp_exp !== 6'h2A || bus.resp_err !== 1'b0) begin errors++; $display("FAIL single_data: q=%h exp=%h err=%b want 000006000003 2a 0", bus.resp_q, bus.resp_exp, bus.resp_err); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: busy=%b want 1", busy); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0 || bus.resp_q !== {24'd6, 24'd3}) begin errors++; $display("FAIL single_after: rv=%b busy=%b q=%h want 0 0 000006000003", bus.resp_valid, busy, bus.resp_q); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_gnt [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    int         exp_id  [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 24'(10 + i), 24'(1 + i));
    gq.delete(); rid_q.delete(); rq_q.delete(); overlap = 0;
    bus.req_valid = 4'b1111;
    for (int t = 0; t < 300 && rid_q.size() < 5; t++) tick();
    bus.req_valid = 4'b0000;
    checks++;
    if (rid_q.size() < 5 || gq.size() < 5) begin
      errors++; $display("FAIL fair_count: resps=%0d grants=%0d want 5", rid_q.size(), gq.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++; if (gq[k] !== exp_gnt[k]) begin errors++; $display("FAIL fair_grant%0d: got %b want %b", k, gq[k], exp_gnt[k]); end
        checks++; if (rid_q[k] != exp_id[k]) begin errors++; $display("FAIL fair_id%0d: got %0d want %0d", k, rid_q[k], exp_id[k]); end
        checks++; if (rq_q[k] !== {24'(10 + exp_id[k]), 24'(1 + exp_id[k])}) begin errors++; $display("FAIL fair_q%0d: got %h", k, rq_q[k]); end
      end
    end
    checks++; if (overlap != 0) begin errors++; $display("FAIL fair_overlap: got %0d want 0", overlap); end
    repeat (20) tick();
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    m_stall = 1'b1;
    set_op(2, 24'd7, 24'd1);
    bus.req_valid = 4'b0100;
    wait_grant(ok);
    checks++; if (!ok || bus.req_ready !== 4'b0100) begin errors++; $display("FAIL to_grant: got %b want 0100", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
    checks++; if (div_enable !== 1'b1) begin errors++; $display("FAIL to_enable: en=%b want 1", div_enable); end
    repeat (TIMEOUT - 1) tick();
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL to_early: rv=%b want 0", bus.resp_valid); end
    tick();
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_id !== 2'd2) begin errors++; $display("FAIL to_resp: rv=%b err=%b id=%0d want 1 1 2", bus.resp_valid, bus.resp_err, bus.resp_id); end
    checks++; if (bus.resp_q !== 48'hFFFFFFFFFFFF || bus.resp_exp !== 6'h00) begin errors++; $display("FAIL to_data: q=%h exp=%h want ffffffffffff 00", bus.resp_q, bus.resp_exp); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle: busy=%b want 0", busy); end
    m_stall = 1'b0;
    tick();
    set_op(0, 24'd9, 24'd4);
    bus.req_valid = 4'b0001;
    wait_grant(ok);
    bus.req_valid = 4'b0000;
    wait_resp(ok);
    checks++; if (!ok || bus.resp_q !== {24'd9, 24'd4} || bus.resp_err !== 1'b0 || bus.resp_id !== 2'd0) begin errors++; $display("FAIL to_recover: q=%h err=%b id=%0d want 000009000004 0 0", bus.resp_q, bus.resp_err, bus.resp_id); end
  endtask

  task automatic test_rdy_low();
    bit ok;
    int stray;
    do_reset();
    m_hold = 1'b1;
    set_op(3, 24'd8, 24'd2);
    bus.req_valid = 4'b1000;
    stray = 0;
    repeat (5) begin tick(); if (bus.req_ready !== 4'b0000 || busy !== 1'b0) stray++; end
    checks++; if (stray != 0) begin errors++; $display("FAIL rdy_hold: grants/busy seen %0d want 0", stray); end
    m_hold = 1'b0;
    tick();
    checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL rdy_grant: got %b want 1000", bus.req_ready); end
    bus.req_valid = 4'b0000;
    wait_resp(ok);
    checks++; if (!ok || bus.resp_id !== 2'd3 || bus.resp_q !== {24'd8, 24'd2}) begin errors++; $display("FAIL rdy_resp: id=%0d q=%h want 3 000008000002", bus.resp_id, bus.resp_q); end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    do_reset();
    set_op(0, 24'd5, 24'd5);
    bus.req_valid = 4'b0001;
    wait_grant(ok);
    bus.req_valid = 4'b0000;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || div_enable !== 1'b0 || div_n !== 24'd0 || div_d !== 24'd0) begin errors++; $display("FAIL rstw_ctl: busy=%b en=%b n=%h d=%h want 0", busy, div_enable, div_n, div_d); end
    checks++; if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b0 || bus.resp_q !== 48'd0) begin errors++; $display("FAIL rstw_out: ready=%b rv=%b q=%h want 0", bus.req_ready, bus.resp_valid, bus.resp_q); end
    tick();
    rid_q.delete();
    rst = 1'b0;
    set_op(1, 24'd4, 24'd2);
    bus.req_valid = 4'b0011;
    wait_grant(ok);
    checks++; if (!ok || bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rstw_ptr: got %b want 0001", bus.req_ready); end
    checks++; if (rid_q.size() != 0) begin errors++; $display("FAIL rstw_noresp: responses %0d want 0", rid_q.size()); end
    bus.req_valid = 4'b0010;
    wait_grant(ok);
    checks++; if (!ok || bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rstw_second: got %b want 0010", bus.req_ready); end
    bus.req_valid = 4'b0000;
  endtask

  task automatic test_zero_div();
    bit ok;
    do_reset();
    set_op(2, 24'd5, 24'd0);
    bus.req_valid = 4'b0100;
    wait_grant(ok);
    checks++; if (!ok || bus.req_ready !== 4'b0100) begin errors++; $display("FAIL zero_grant: got %b want 0100", bus.req_ready); end
    bus.req_valid = 4'b0000;
    tick();
`ifdef DIVARB_ZERO_BYPASS_EN
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.resp_id !== 2'd2) begin errors++; $display("FAIL zero_resp: rv=%b err=%b id=%0d want 1 1 2", bus.resp_valid, bus.resp_err, bus.resp_id); end
    checks++; if (bus.resp_q !== 48'hFFFFFFFFFFFF || bus.resp_exp !== 6'h00) begin errors++; $display("FAIL zero_data: q=%h exp=%h want ffffffffffff 00", bus.resp_q, bus.resp_exp); end
    checks++; if (div_enable !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL zero_nodiv: en=%b busy=%b want 0 1", div_enable, busy); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0 || busy !== 1'b0 || div_enable !== 1'b0) begin errors++; $display("FAIL zero_after: rv=%b busy=%b en=%b want 0 0 0", bus.resp_valid, busy, div_enable); end
`else
    checks++; if (div_enable !== 1'b1 || div_d !== 24'd0) begin errors++; $display("FAIL zero_enable: en=%b d=%h want 1 0", div_enable, div_d); end
    repeat (13) tick();
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_id !== 2'd2) begin errors++; $display("FAIL zero_resp: rv=%b err=%b id=%0d want 1 0 2", bus.resp_valid, bus.resp_err, bus.resp_id); end
    checks++; if (bus.resp_q !== {24'd5, 24'd0} || bus.resp_exp !== 6'h2A) begin errors++; $display("FAIL zero_data: q=%h exp=%h want 000005000000 2a", bus.resp_q, bus.resp_exp); end
`endif
  endtask

  initial begin
    rst = 1'b1;
    m_stall = 1'b0;
    m_hold = 1'b0;
    overlap = 0;
    bus.req_valid = '0;
    bus.req_n = '0;
    bus.req_d = '0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_rdy_low();
    test_reset_in_wait();
    test_zero_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end
endmodule

// File: doc/divide_arbiter.md
Name: divide_arbiter

Overview:
- Shares one divide_Newton instance among NREQ requesters, using round-robin arbitration.
- Per requester: valid/ready request handshake; the arbiter holds the chosen operands stable and drives the divider's enable.
- Waits for the divider's VALID, captures Q/EXP and returns them with the requester ID as a one-cycle response pulse.
- Sits between client blocks (scalers, normalisers) and the single divider instance.

Parameters:
- DSIZE, 24, operand width; must match the divider.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to clog2(NREQ).
- TIMEOUT, 63, watchdog limit in cycles, counted from the div_enable cycle until div_valid.

Ports:
- clock  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester request
- req_n  in  NREQ*DSIZE  dividends, requester i in slice [i*DSIZE +: DSIZE]
- req_d  in  NREQ*DSIZE  divisors, same slicing as req_n
- req_ready  out  NREQ  one-hot grant pulse
- resp_valid  out  1  response pulse
- resp_id  out  IDW  index of the requester being answered
- resp_q  out  2*DSIZE  captured quotient
- resp_exp  out  6  captured exponent
- resp_err  out  1  timeout, or zero-divisor bypass
- busy  out  1  high in every state except IDLE
- div_n  out  DSIZE  to divider N
- div_d  out  DSIZE  to divider D
- div_enable  out  1  to divider enable
- div_q  in  2*DSIZE  from divider Q
- div_exp  in  6  from divider EXP
- div_valid  in  1  from divider VALID
- div_rdy  in  1  from divider RDY

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer 0; watchdog 0. Reset mid-operation abandons the transaction with no response. The divider shares rst.
- All outputs are registered.
- Requester rules: a requester holds req_valid and its operands stable until it sees its req_ready bit. The arbiter never deasserts a pending grant decision.
- IDLE:
  - Acts only when div_rdy=1 and |req_valid.
  - Winner = first set bit of req_valid, scanning from the pointer upward with wrap-around.
  - Next cycle: req_ready[winner]=1 for exactly one cycle; div_n/div_d loaded from the winner's slice; cur_id=winner; pointer=winner+1 mod NREQ; state to ISSUE.
  - If div_rdy=0, stay in IDLE and issue no grants.
- ISSUE:
  - div_enable=1 for exactly one cycle, with div_n/div_d already stable that cycle. Watchdog cleared.
  - Next state WAIT.
- WAIT:
  - div_enable=0; div_n/div_d held; watchdog increments each cycle.
  - On the first cycle div_valid=1: capture div_q/div_exp, resp_err=0, go to RESP.
  - If the watchdog reaches TIMEOUT first: resp_q all ones, resp_exp=0, resp_err=1, go to RESP.
  - div_valid outside WAIT is ignored.
- RESP:
  - resp_valid=1 and resp_id=cur_id for one cycle; no backpressure. resp_q/resp_exp/resp_err hold until the next RESP.
  - Next state IDLE.
- Back-to-back requests: the response requester may assert req_valid during RESP. It is arbitrated in IDLE under normal round-robin, so another pending requester wins first if the pointer favours it.
- Throughput: minimum 3 cycles of overhead plus divider latency per operation. Grant-to-response = 2 + divider latency (counted from div_enable to div_valid).
- Fairness: with all requesters continuously requesting, each is granted exactly once per NREQ operations.

Optional Feature:
- Macro DIVARB_ZERO_BYPASS_EN.
- Defined: a winner whose divisor is 0 is still granted (req_ready pulse) but skips the divider. State goes IDLE→RESP directly, with resp_q all ones, resp_exp=0, resp_err=1. div_enable is not asserted and busy is high for that RESP cycle.
- Undefined: a zero divisor is forwarded to the divider like any other operand, and resp_err is set only by timeout.

Decomposition:
- Package divide_arb_pkg:
  - state encoding IDLE=0, ISSUE=1, WAIT=2, RESP=3
  - ERR_Q constant (all ones)
  - EXP_W=6
  - clog2 function for IDW
- Sub-module divide_rr_pick: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are a one-hot grant and the winner index. Instantiated once.

Test Plan:
- Bench divider model: RDY low from enable until VALID; VALID arrives 12 cycles after enable; Q={N,D}; EXP=6'h2A.
- Single request: req 1 with N=6, D=3 → req_ready=4'b0010 one cycle; div_enable one cycle later; resp_valid 14 cycles after the grant; resp_id=1, resp_q={24'd6,24'd3}, resp_exp=6'h2A, resp_err=0.
- All four requesting continuously from reset → grant order 0,1,2,3,0; each resp_id matches its grant; no overlapping div_enable.
- Model stalls VALID forever → resp_err=1 and resp_q=48'hFFFFFFFFFFFF exactly TIMEOUT cycles after div_enable; state returns to IDLE; the next request is served normally.
- div_rdy forced 0 with req_valid=4'b1000 → no grant; after div_rdy rises, grant 3 follows on the next cycle.
- rst asserted in WAIT → all outputs 0 immediately; no resp_valid; pointer restarts at 0, so simultaneous requests 4'b0011 grant 0 first.
- With DIVARB_ZERO_BYPASS_EN, req 2 with D=0 → grant, then resp_valid on the next cycle with resp_err=1 and no div_enable. Without the macro, the same stimulus produces div_enable and a normal model response.
